// File: rtl/mac_seq_pkg.sv
// Shared types for the multiply-accumulate sequencer: FSM state encoding and
// the derived term-index width helper.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MULT_ISSUE = 3'd1,
    MULT_WAIT  = 3'd2,
    ADD_ISSUE  = 3'd3,
    ADD_WAIT   = 3'd4
  } state_e;

  function automatic int idx_width(input int num_terms);
    return (num_terms <= 1) ? 1 : $clog2(num_terms);
  endfunction

endpackage

// File: rtl/mac_sequencer.sv
// Multiply-accumulate sequencer: out = c + sum(a[i]*b[i]) using external multiplier
// and adder cores. Define MAC_SEQ_OVERLAP_EN to overlap the next multiply with each add.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_TERMS  = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [DATA_WIDTH*NUM_TERMS-1:0] a_values,
  input  logic [DATA_WIDTH*NUM_TERMS-1:0] b_values,
  input  logic [DATA_WIDTH-1:0]           c_value,
  output logic [DATA_WIDTH-1:0]           mult_a,
  output logic [DATA_WIDTH-1:0]           mult_b,
  output logic                            mult_start,
  input  logic [DATA_WIDTH-1:0]           mult_result,
  input  logic                            mult_result_ready,
  output logic [DATA_WIDTH-1:0]           add_a,
  output logic [DATA_WIDTH-1:0]           add_b,
  output logic                            add_start,
  input  logic [DATA_WIDTH-1:0]           add_result,
  input  logic                            add_result_ready,
  output logic [DATA_WIDTH-1:0]           out_value,
  output logic                            data_ready,
  output logic                            busy
);

  localparam int IDX_WIDTH = idx_width(NUM_TERMS);
  // Operand bank is rounded up to a power of two so every index value is in range.
  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TERMS - 1);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   a_q [DEPTH];
  logic [DATA_WIDTH-1:0]   b_q [DEPTH];
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [DATA_WIDTH-1:0]   mult_a_q;
  logic [DATA_WIDTH-1:0]   mult_b_q;
  logic                    mult_start_q;
  logic [DATA_WIDTH-1:0]   add_a_q;
  logic [DATA_WIDTH-1:0]   add_b_q;
  logic                    add_start_q;
  logic [DATA_WIDTH-1:0]   out_value_q;
  logic                    data_ready_q;
  logic                    busy_q;

  logic [DEPTH*DATA_WIDTH-1:0] a_pad_s;
  logic [DEPTH*DATA_WIDTH-1:0] b_pad_s;
  logic [IDX_WIDTH-1:0]        idx_d;
  logic                        is_last_s;

`ifdef MAC_SEQ_OVERLAP_EN
  logic [DATA_WIDTH-1:0] prod_q;
  logic                  add_got_q;
  logic                  mult_got_q;
  logic [IDX_WIDTH-1:0]  idx_nn_s;
  logic                  add_have_s;
  logic                  mult_have_s;
  logic [DATA_WIDTH-1:0] acc_eff_s;
  logic [DATA_WIDTH-1:0] prod_eff_s;
`endif

  assign a_pad_s = (DEPTH*DATA_WIDTH)'(a_values);
  assign b_pad_s = (DEPTH*DATA_WIDTH)'(b_values);

  always_comb begin
    idx_d     = idx_q + IDX_WIDTH'(1);
    is_last_s = (idx_q == LAST_IDX);
`ifdef MAC_SEQ_OVERLAP_EN
    idx_nn_s    = idx_q + IDX_WIDTH'(2);
    // A result arriving this cycle counts as already latched.
    add_have_s  = add_got_q | add_result_ready;
    mult_have_s = mult_got_q | mult_result_ready;
    acc_eff_s   = add_got_q ? acc_q : add_result;
    prod_eff_s  = mult_got_q ? prod_q : mult_result;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_start_q <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      add_start_q  <= 1'b0;
      out_value_q  <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
`ifdef MAC_SEQ_OVERLAP_EN
      prod_q     <= '0;
      add_got_q  <= 1'b0;
      mult_got_q <= 1'b0;
`endif
    end else begin
      mult_start_q <= 1'b0;
      add_start_q  <= 1'b0;
      data_ready_q <= 1'b0;
      if (abort && (state_q != IDLE)) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              for (int i = 0; i < DEPTH; i++) begin
                a_q[i] <= a_pad_s[i*DATA_WIDTH +: DATA_WIDTH];
                b_q[i] <= b_pad_s[i*DATA_WIDTH +: DATA_WIDTH];
              end
              acc_q        <= c_value;
              idx_q        <= '0;
              mult_a_q     <= a_pad_s[0 +: DATA_WIDTH];
              mult_b_q     <= b_pad_s[0 +: DATA_WIDTH];
              mult_start_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= MULT_ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
          MULT_ISSUE: begin
            state_q <= MULT_WAIT;
          end
          MULT_WAIT: begin
            if (mult_result_ready) begin
              add_a_q     <= acc_q;
              add_b_q     <= mult_result;
              add_start_q <= 1'b1;
              state_q     <= ADD_ISSUE;
`ifdef MAC_SEQ_OVERLAP_EN
              add_got_q  <= 1'b0;
              mult_got_q <= is_last_s;
              if (!is_last_s) begin
                mult_a_q     <= a_q[idx_d];
                mult_b_q     <= b_q[idx_d];
                mult_start_q <= 1'b1;
              end else begin
                mult_start_q <= 1'b0;
              end
`endif
            end else begin
              state_q <= MULT_WAIT;
            end
          end
          ADD_ISSUE: begin
            state_q <= ADD_WAIT;
          end
          ADD_WAIT: begin
`ifdef MAC_SEQ_OVERLAP_EN
            if (add_result_ready && !add_got_q) begin
              acc_q     <= add_result;
              add_got_q <= 1'b1;
            end else begin
              add_got_q <= add_got_q;
            end
            if (mult_result_ready && !mult_got_q) begin
              prod_q     <= mult_result;
              mult_got_q <= 1'b1;
            end else begin
              mult_got_q <= mult_got_q;
            end
            if (add_have_s && mult_have_s) begin
              if (is_last_s) begin
                out_value_q  <= acc_eff_s;
                data_ready_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= IDLE;
              end else begin
                // Next add issues straight from the latched pair; next multiply overlaps it.
                idx_q       <= idx_d;
                add_a_q     <= acc_eff_s;
                add_b_q     <= prod_eff_s;
                add_start_q <= 1'b1;
                add_got_q   <= 1'b0;
                mult_got_q  <= (idx_d == LAST_IDX);
                state_q     <= ADD_ISSUE;
                if (idx_d != LAST_IDX) begin
                  mult_a_q     <= a_q[idx_nn_s];
                  mult_b_q     <= b_q[idx_nn_s];
                  mult_start_q <= 1'b1;
                end else begin
                  mult_start_q <= 1'b0;
                end
              end
            end else begin
              state_q <= ADD_WAIT;
            end
`else
            if (add_result_ready) begin
              acc_q <= add_result;
              if (is_last_s) begin
                out_value_q  <= add_result;
                data_ready_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= IDLE;
              end else begin
                idx_q        <= idx_d;
                mult_a_q     <= a_q[idx_d];
                mult_b_q     <= b_q[idx_d];
                mult_start_q <= 1'b1;
                state_q      <= MULT_ISSUE;
              end
            end else begin
              state_q <= ADD_WAIT;
            end
`endif
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign mult_start = mult_start_q;
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_start  = add_start_q;
  assign out_value  = out_value_q;
  assign data_ready = data_ready_q;
  assign busy       = busy_q;

endmodule
